// File: rtl/add_sub_pipe_if.sv
// rtl/add_sub_pipe_if.sv - operand/result stream bundle for add_sub_pipe
//
// Purpose: groups the operand beat handshake (in_valid/in_ready), the
// operation select, the operands, and the result beat handshake
// (out_valid/out_ready) with the result and flags.
// Ports (signals):
//   in_valid, in_ready     operand beat handshake
//   sel_add_sub            0 = in0 + in1, 1 = in0 - in1
//   in0, in1               operands (WIDTH)
//   out_valid, out_ready   result beat handshake
//   s                      result (WIDTH)
//   c_out, ovf, zero, neg  result flags
//   sel_sat                signed saturation select, only with ADD_SUB_PIPE_SAT_EN
// Modports: master drives operands and out_ready, slave is the adder.
interface add_sub_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             sel_add_sub;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
`ifdef ADD_SUB_PIPE_SAT_EN
    logic             sel_sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
`ifdef ADD_SUB_PIPE_SAT_EN
        output sel_sat,
`endif
        output in_valid, sel_add_sub, in0, in1, out_ready,
        input  in_ready, out_valid, s, c_out, ovf, zero, neg
    );

    modport slave (
`ifdef ADD_SUB_PIPE_SAT_EN
        input  sel_sat,
`endif
        input  in_valid, sel_add_sub, in0, in1, out_ready,
        output in_ready, out_valid, s, c_out, ovf, zero, neg
    );
endinterface

// File: rtl/add_sub_pipe.sv
// rtl/add_sub_pipe.sv - pipelined add/subtract with sliced carry chain
//
// Purpose: computes in0 + in1 or in0 - in1 (as in0 + ~in1 + 1) over STAGES
// pipeline stages; stage k adds bit slice k using the carry registered by
// stage k-1. The last stage register is the output register.
// Parameters: WIDTH (>= 4), STAGES (WIDTH must be a multiple of STAGES).
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    add_sub_pipe_if.slave (operand and result streams, flags)
// Optional feature: define ADD_SUB_PIPE_SAT_EN to add the sel_sat input and
// signed saturation of the result on overflow.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_pipe_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Whole pipeline moves in lockstep; a stalled output freezes everything.
    logic advance;

    // Per-stage registers: valid, carry out of the slice just computed,
    // operand skew (a, post-inversion b) and partially built result.
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic             v_d [STAGES];
    logic             c_d [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];

    // Stage inputs: stage 0 sees the operand port, stage k sees stage k-1.
    logic             pv [STAGES];
    logic             pc [STAGES];
    logic [WIDTH-1:0] pa [STAGES];
    logic [WIDTH-1:0] pb [STAGES];
    logic [WIDTH-1:0] pr [STAGES];

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
    logic neg_q, neg_d;

`ifdef ADD_SUB_PIPE_SAT_EN
    logic sat_q [STAGES];
    logic sat_d [STAGES];
    logic psat  [STAGES];
`endif

    assign advance = !v_q[LAST] || bus.out_ready;

    always_comb begin : stage_inputs
        pv[0] = bus.in_valid;
        pc[0] = bus.sel_add_sub;
        pa[0] = bus.in0;
        pb[0] = bus.sel_add_sub ? ~bus.in1 : bus.in1;
        pr[0] = '0;
`ifdef ADD_SUB_PIPE_SAT_EN
        psat[0] = bus.sel_sat;
`endif
        for (int k = 1; k < STAGES; k++) begin
            pv[k] = v_q[k-1];
            pc[k] = c_q[k-1];
            pa[k] = a_q[k-1];
            pb[k] = b_q[k-1];
            pr[k] = r_q[k-1];
`ifdef ADD_SUB_PIPE_SAT_EN
            psat[k] = sat_q[k-1];
`endif
        end
    end

    always_comb begin : stage_logic
        logic [SW:0] sum;
        logic        a_msb;
        logic        b_msb;
        sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum = {1'b0, pa[k][k*SW +: SW]} + {1'b0, pb[k][k*SW +: SW]}
                + {{SW{1'b0}}, pc[k]};
            v_d[k] = pv[k];
            c_d[k] = sum[SW];
            a_d[k] = pa[k];
            b_d[k] = pb[k];
            r_d[k] = pr[k];
            r_d[k][k*SW +: SW] = sum[SW-1:0];
`ifdef ADD_SUB_PIPE_SAT_EN
            sat_d[k] = psat[k];
`endif
        end
        // Flags come from the full result formed in the last stage; b is the
        // already-inverted operand, so one overflow rule covers add and sub.
        a_msb = pa[LAST][WIDTH-1];
        b_msb = pb[LAST][WIDTH-1];
        ovf_d = (a_msb == b_msb) && (r_d[LAST][WIDTH-1] != a_msb);
`ifdef ADD_SUB_PIPE_SAT_EN
        // Clamp toward the sign of in0; carry out is left as computed.
        if (psat[LAST] && ovf_d) begin
            r_d[LAST] = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        zero_d = (r_d[LAST] == '0);
        neg_d  = r_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
`ifdef ADD_SUB_PIPE_SAT_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (advance) begin
            // Bubbles shift like beats so every beat keeps its slot.
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                r_q[k] <= r_d[k];
`ifdef ADD_SUB_PIPE_SAT_EN
                sat_q[k] <= sat_d[k];
`endif
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = v_q[LAST];
    assign bus.s         = r_q[LAST];
    assign bus.c_out     = c_q[LAST];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb/tb_add_sub_pipe.sv - self-checking bench for add_sub_pipe
module tb_add_sub_pipe;
    localparam int W  = 32;
    localparam int ST = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
        logic         n;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    add_sub_pipe_if #(.WIDTH(W)) bus ();

    add_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_lat;
    exp_t q[$];
    logic [W-1:0] last_s;
    logic last_c, last_v, last_z, last_n;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic and signed-range reasoning.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic sat);
        exp_t         e;
        logic [W:0]   full;
        longint       sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = sub ? (sa - sb) : (sa + sb);
        full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.s = full[W-1:0];
        e.c = sub ? (a >= b) : full[W];
        e.v = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
        if (sat && e.v) e.s = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        e.acc = 0;
        return e;
    endfunction

    function automatic logic [63:0] pack(input logic [W-1:0] s, input logic c,
                                         input logic v, input logic z, input logic n);
        return {28'd0, c, v, z, n, s};
    endfunction

    // One clock: drive at negedge, observe 1ns later, before the next posedge.
    task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic sat, input logic ordy, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.in_valid    = iv;
        bus.in0         = a;
        bus.in1         = b;
        bus.sel_add_sub = sub;
`ifdef ADD_SUB_PIPE_SAT_EN
        bus.sel_sat     = sat;
`endif
        bus.out_ready   = ordy;
        #1;
        cyc++;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
                e = q[0];
                check("result", pack(bus.s, bus.c_out, bus.ovf, bus.zero, bus.neg),
                      pack(e.s, e.c, e.v, e.z, e.n));
                if (ordy) begin
                    last_lat = cyc - e.acc;
                    last_s = bus.s; last_c = bus.c_out; last_v = bus.ovf;
                    last_z = bus.zero; last_n = bus.neg;
                    void'(q.pop_front());
                end
            end
        end
        check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || ordy));
        acc = iv && bus.in_ready;
        if (acc) begin
            e = model(a, b, sub, sat);
            e.acc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic drain();
        logic acc;
        int   n = 0;
        while (q.size() != 0 && n < 60) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            n++;
        end
        check("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic sat, input logic [W-1:0] es,
                            input logic ec, input logic ev, input logic ez, input logic en);
        logic acc;
        drain();
        last_s = 'x; last_c = 'x; last_v = 'x; last_z = 'x; last_n = 'x; last_lat = -1;
        step(1'b1, a, b, sub, sat, 1'b1, acc);
        check({tag, "_accept"}, 64'(acc), 64'd1);
        drain();
        check({tag, "_s"}, 64'(last_s), 64'(es));
        check({tag, "_flags"}, {60'd0, last_c, last_v, last_z, last_n}, {60'd0, ec, ev, ez, en});
        check({tag, "_latency_edges"}, 64'(last_lat - 1), 64'(ST - 1));
    endtask

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] t [5];
        t[0] = 32'h0; t[1] = 32'h1; t[2] = 32'h7FFFFFFF; t[3] = 32'h80000000; t[4] = 32'hFFFFFFFF;
        if ($urandom_range(0, 3) == 0) return t[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic acc;
        int   c;
        int   sent;
        bus.in_valid = 1'b0; bus.in0 = '0; bus.in1 = '0; bus.sel_add_sub = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADD_SUB_PIPE_SAT_EN
        bus.sel_sat = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out", pack(bus.s, bus.c_out, bus.ovf, bus.zero, bus.neg) | {27'd0, bus.out_valid, 36'd0}, 64'd0);

        directed("add_wrap", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        directed("sub_5_7", 32'h5, 32'h7, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        directed("sub_7_5", 32'h7, 32'h5, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
        directed("add_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef ADD_SUB_PIPE_SAT_EN
        directed("add_sat", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        directed("sub_sat", 32'h80000000, 32'h1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        directed("sub_ovf", 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

        // Eight back-to-back beats with a three-cycle output stall mid-stream.
        c = 0; sent = 0;
        while ((sent < 8 || q.size() != 0) && c < 60) begin
            logic rdy;
            rdy = !(c >= 4 && c < 7);
            step(sent < 8, W'(sent), W'(100 * sent), 1'b0, 1'b0, rdy, acc);
            if (!rdy) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            if (acc) sent++;
            c++;
        end
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_left", 64'(q.size()), 64'd0);

        // Reset with beats in flight: nothing accepted earlier may come out.
        for (int i = 0; i < 5; i++) step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b0, acc);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
            check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        end
        directed("post_rst", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h01234567, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 500; i++) begin
            logic sat;
            sat = 1'b0;
`ifdef ADD_SUB_PIPE_SAT_EN
            sat = 1'($urandom_range(0, 1));
`endif
            step($urandom_range(0, 3) != 0, rand_op(), rand_op(), 1'($urandom_range(0, 1)),
                 sat, $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
